// File: rtl/ascon_seq_pkg.sv
// Shared types and constants for the ASCON host sequencer: FSM state
// encoding, the core opcode values the sequencer must recognise, and
// the opcode classifier used by the fetch and wait logic.
package ascon_seq_pkg;

  // Opcode that terminates a program and parks the core command bus.
  localparam logic [5:0] HALT_OP = 6'h3f;

  // Core command opcodes (same encodings as the core's opcode table).
  localparam logic [5:0] ASCON_KEY_LOAD           = 6'h01;
  localparam logic [5:0] ASCON_NONCE_LOAD         = 6'h02;
  localparam logic [5:0] ASCON_INIT               = 6'h03;
  localparam logic [5:0] ASCON_ENCRYPT            = 6'h04;
  localparam logic [5:0] ASCON_DECRYPT            = 6'h05;
  localparam logic [5:0] ASCON_DATA_FIFO_PUSH     = 6'h10;
  localparam logic [5:0] ASCON_TXT_FIFO_PUSH      = 6'h11;
  localparam logic [5:0] ASCON_TEXT_OUT_FIFO_PULL = 6'h12;

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_IDLE   = 4'd1,
    S_FETCH  = 4'd2,
    S_BLK    = 4'd3,
    S_ISSUE  = 4'd4,
    S_SETTLE = 4'd5,
    S_WAIT   = 4'd6,
    S_OUT    = 4'd7,
    S_HALT   = 4'd8
  } seq_state_e;

  typedef enum logic [1:0] {
    OPC_PLAIN     = 2'd0,
    OPC_DATA_PUSH = 2'd1,
    OPC_TXT_PUSH  = 2'd2,
    OPC_OUT_PULL  = 2'd3
  } op_class_e;

  // Pushes need a block from the input stream, pulls return a result;
  // everything else is a plain command.
  function automatic op_class_e classify_op(input logic [5:0] op);
    op_class_e cls;
    case (op)
      ASCON_DATA_FIFO_PUSH:     cls = OPC_DATA_PUSH;
      ASCON_TXT_FIFO_PUSH:      cls = OPC_TXT_PUSH;
      ASCON_TEXT_OUT_FIFO_PULL: cls = OPC_OUT_PULL;
      default:                  cls = OPC_PLAIN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ascon_seq_imem.sv
// Instruction memory for the ASCON host sequencer: synchronous write,
// asynchronous read, DEPTH x 6-bit opcodes. The array has no reset so a
// loaded program survives a sequencer reset.
module ascon_seq_imem #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem_r [DEPTH];

  // Store one opcode per write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ascon_host_sequencer.sv
// Hardware initiator for the ASCON core command interface. Runs a small
// opcode program from local memory, feeds push blocks from an input
// stream, waits on the core ready flag and returns pulled output blocks
// on a result stream. All outputs come straight from registers.
module ascon_host_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int PROG_DEPTH = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [5:0]                    prog_data,
  input  logic                          start,
  input  logic                          fast_mode,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  input  logic [WIDTH-1:0]              blk_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [WIDTH-1:0]              res_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [5:0]                    instruction,
  output logic [WIDTH-1:0]              data_block,
  output logic [WIDTH-1:0]              txt_block,
  output logic                          data_blk_en,
  output logic                          txt_blk_en,
  output logic                          compact_fast,
  input  logic [10:0]                   status_reg,
  input  logic [WIDTH-1:0]              ascon_out
);

  localparam int AW  = $clog2(PROG_DEPTH);
  localparam int PCW = AW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [PCW-1:0] PC_END     = PCW'(PROG_DEPTH);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  seq_state_e       state_r, state_s;
  logic [PCW-1:0]   pc_r, pc_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic [5:0]       op_r, op_s;
  logic             fast_r, fast_s;
  logic             error_r, error_s;
  logic [5:0]       instruction_r, instruction_s;
  logic [WIDTH-1:0] data_block_r, data_block_s;
  logic [WIDTH-1:0] txt_block_r, txt_block_s;
  logic             data_blk_en_r, data_blk_en_s;
  logic             txt_blk_en_r, txt_blk_en_s;
  logic             blk_ready_r, blk_ready_s;
  logic             res_valid_r, res_valid_s;
  logic [WIDTH-1:0] res_data_r, res_data_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic             mem_we_s;
  logic [5:0]       mem_op_s;
  op_class_e        fetch_cls_s;
  op_class_e        op_cls_s;
  logic             core_ready_s;
  logic             unused_status_s;

  // The program may only change while no program is running.
  assign mem_we_s = prog_we && ((state_r == S_IDLE) || (state_r == S_BOOT));

  ascon_seq_imem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_r[AW-1:0]),
    .rdata (mem_op_s)
  );

  assign fetch_cls_s     = classify_op(mem_op_s);
  assign op_cls_s        = classify_op(op_r);
  assign core_ready_s    = status_reg[0];
  assign unused_status_s = ^status_reg[10:1];

  // Next-state and next-output decode; every register holds by default
  // and the load strobes and done fall back to zero.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    timer_s       = timer_r;
    op_s          = op_r;
    fast_s        = fast_r;
    error_s       = error_r;
    instruction_s = instruction_r;
    data_block_s  = data_block_r;
    txt_block_s   = txt_block_r;
    data_blk_en_s = 1'b0;
    txt_blk_en_s  = 1'b0;
    res_valid_s   = res_valid_r;
    res_data_s    = res_data_r;
    done_s        = 1'b0;

    case (state_r)
      S_BOOT: begin
        if (core_ready_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_BOOT;
        end
      end

      S_IDLE: begin
        if (start) begin
          pc_s    = '0;
          fast_s  = fast_mode;
          error_s = 1'b0;
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_FETCH: begin
        if ((pc_r == PC_END) || (mem_op_s == HALT_OP)) begin
          state_s = S_HALT;
        end else begin
          op_s = mem_op_s;
          if ((fetch_cls_s == OPC_DATA_PUSH) || (fetch_cls_s == OPC_TXT_PUSH)) begin
            state_s = S_BLK;
          end else begin
            state_s = S_ISSUE;
          end
        end
      end

      S_BLK: begin
        if (blk_valid && blk_ready_r) begin
          instruction_s = op_r;
          if (op_cls_s == OPC_DATA_PUSH) begin
            data_block_s  = blk_data;
            data_blk_en_s = 1'b1;
          end else begin
            txt_block_s  = blk_data;
            txt_blk_en_s = 1'b1;
          end
          state_s = S_SETTLE;
        end else begin
          state_s = S_BLK;
        end
      end

      S_ISSUE: begin
        instruction_s = op_r;
        state_s       = S_SETTLE;
      end

      // The core drops ready one cycle after a command, so the flag is
      // not trusted in this cycle.
      S_SETTLE: begin
        timer_s = '0;
        state_s = S_WAIT;
      end

      S_WAIT: begin
        if (core_ready_s) begin
          if (op_cls_s == OPC_OUT_PULL) begin
            res_data_s  = ascon_out;
            res_valid_s = 1'b1;
            state_s     = S_OUT;
          end else begin
            pc_s    = pc_r + PCW'(1);
            state_s = S_FETCH;
          end
        end else if (timer_r == TIMER_LAST) begin
          error_s       = 1'b1;
          instruction_s = HALT_OP;
          state_s       = S_HALT;
        end else begin
          timer_s = timer_r + TW'(1);
          state_s = S_WAIT;
        end
      end

      // No skid buffer: the program stalls until the result is taken.
      S_OUT: begin
        if (res_ready) begin
          res_valid_s = 1'b0;
          pc_s        = pc_r + PCW'(1);
          state_s     = S_FETCH;
        end else begin
          state_s = S_OUT;
        end
      end

      S_HALT: begin
        instruction_s = HALT_OP;
        done_s        = ~error_r;
        state_s       = S_IDLE;
      end

      default: begin
        state_s = S_BOOT;
      end
    endcase

    blk_ready_s = (state_s == S_BLK);
    busy_s      = (state_s != S_BOOT) && (state_s != S_IDLE);
  end

  // State and output registers; reset parks the core command bus on HALT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= S_BOOT;
      pc_r          <= '0;
      timer_r       <= '0;
      op_r          <= HALT_OP;
      fast_r        <= 1'b0;
      error_r       <= 1'b0;
      instruction_r <= HALT_OP;
      data_block_r  <= '0;
      txt_block_r   <= '0;
      data_blk_en_r <= 1'b0;
      txt_blk_en_r  <= 1'b0;
      blk_ready_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_data_r    <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      timer_r       <= timer_s;
      op_r          <= op_s;
      fast_r        <= fast_s;
      error_r       <= error_s;
      instruction_r <= instruction_s;
      data_block_r  <= data_block_s;
      txt_block_r   <= txt_block_s;
      data_blk_en_r <= data_blk_en_s;
      txt_blk_en_r  <= txt_blk_en_s;
      blk_ready_r   <= blk_ready_s;
      res_valid_r   <= res_valid_s;
      res_data_r    <= res_data_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign blk_ready    = blk_ready_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign instruction  = instruction_r;
  assign data_block   = data_block_r;
  assign txt_block    = txt_block_r;
  assign data_blk_en  = data_blk_en_r;
  assign txt_blk_en   = txt_blk_en_r;
  assign compact_fast = fast_r;

endmodule

// File: tb/tb_ascon_host_sequencer.sv
// Directed bench for ascon_host_sequencer with a small behavioural core:
// the core drops ready for a few cycles after every new command or block
// strobe and returns txt_block[k] ^ (xor of all data blocks) for pull k.
module tb_ascon_host_sequencer;
  import ascon_seq_pkg::*;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rstn;
  logic         prog_we;
  logic [4:0]   prog_addr;
  logic [5:0]   prog_data;
  logic         start;
  logic         fast_mode;
  logic         blk_valid;
  logic         blk_ready;
  logic [W-1:0] blk_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [5:0]   instruction;
  logic [W-1:0] data_block;
  logic [W-1:0] txt_block;
  logic         data_blk_en;
  logic         txt_blk_en;
  logic         compact_fast;
  logic [10:0]  status_reg;
  logic [W-1:0] ascon_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  logic [W-1:0] exp_blk_q [$];
  logic [W-1:0] exp_res_q [$];
  logic [W-1:0] exp_dacc;

  ascon_host_sequencer #(
    .WIDTH      (W),
    .PROG_DEPTH (32),
    .TIMEOUT    (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .fast_mode    (fast_mode),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .instruction  (instruction),
    .data_block   (data_block),
    .txt_block    (txt_block),
    .data_blk_en  (data_blk_en),
    .txt_blk_en   (txt_blk_en),
    .compact_fast (compact_fast),
    .status_reg   (status_reg),
    .ascon_out    (ascon_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural core ----------------
  logic         core_en;
  int           core_busy;
  logic [5:0]   prev_instr;
  logic [W-1:0] txt_mem [4];
  logic [W-1:0] dacc;
  logic [1:0]   txt_idx;
  logic [1:0]   out_idx;

  assign status_reg = {10'd0, core_en && (core_busy == 0)};
  assign ascon_out  = txt_mem[out_idx] ^ dacc;

  // Core model: busy window after each command, block capture, output pointer.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_busy  <= 0;
      prev_instr <= 6'h3f;
    end else begin
      prev_instr <= instruction;
      if ((instruction != prev_instr) || data_blk_en || txt_blk_en) core_busy <= 3;
      else if (core_busy > 0) core_busy <= core_busy - 1;
      if (start) begin
        dacc    <= '0;
        txt_idx <= 2'd0;
        out_idx <= 2'd0;
      end else begin
        if (data_blk_en) dacc <= dacc ^ data_block;
        if (txt_blk_en) begin
          txt_mem[txt_idx] <= txt_block;
          txt_idx          <= txt_idx + 2'd1;
        end
        if (res_valid && res_ready) out_idx <= out_idx + 2'd1;
      end
    end
  end

  // Count cycles with done high.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_op(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic fm);
    @(negedge clk);
    start = 1'b1; fast_mode = fm;
    @(negedge clk);
    start = 1'b0; fast_mode = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy !== 1'b0) && (t < 400)) begin @(negedge clk); t++; end
    check(tag, {127'd0, t < 400}, {127'd0, 1'b1});
    @(negedge clk);
  endtask

  task automatic push_blk(input logic is_txt, input logic [W-1:0] v, input int gap);
    int t = 0;
    logic [5:0] hold;
    logic [5:0] exp_op;
    exp_op = is_txt ? ASCON_TXT_FIFO_PUSH : ASCON_DATA_FIFO_PUSH;
    while ((blk_ready !== 1'b1) && (t < 200)) begin @(negedge clk); t++; end
    check("blk_ready_wait", {127'd0, t < 200}, {127'd0, 1'b1});
    hold = instruction;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("gap_no_strobe", {126'd0, data_blk_en, txt_blk_en}, '0);
      check("gap_instr_hold", {122'd0, instruction}, {122'd0, hold});
      check("gap_ready_held", {127'd0, blk_ready}, {127'd0, 1'b1});
    end
    exp_blk_q.push_back(v);
    blk_data  = v;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    check(is_txt ? "txt_strobe" : "data_strobe", {126'd0, data_blk_en, txt_blk_en},
          is_txt ? {126'd0, 2'b01} : {126'd0, 2'b10});
    check(is_txt ? "txt_block" : "data_block", is_txt ? txt_block : data_block, exp_blk_q.pop_front());
    check("push_instr", {122'd0, instruction}, {122'd0, exp_op});
    @(negedge clk);
    check("strobe_one_cycle", {126'd0, data_blk_en, txt_blk_en}, '0);
  endtask

  task automatic pull_res(input int delay);
    int t = 0;
    logic [W-1:0] held;
    logic [5:0]   hold_i;
    while ((res_valid !== 1'b1) && (t < 200)) begin @(negedge clk); t++; end
    check("res_valid_wait", {127'd0, t < 200}, {127'd0, 1'b1});
    check("pull_instr", {122'd0, instruction}, {122'd0, ASCON_TEXT_OUT_FIFO_PULL});
    held   = res_data;
    hold_i = instruction;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("stall_res_data", res_data, held);
      check("stall_res_valid", {127'd0, res_valid}, {127'd0, 1'b1});
      check("stall_instr", {122'd0, instruction}, {122'd0, hold_i});
    end
    check("res_data", res_data, exp_res_q.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", {127'd0, res_valid}, '0);
  endtask

  // One pass of the encryption-style program.
  task automatic run_enc(input int gap, input int delay, input logic drop_write);
    logic [W-1:0] v;
    int d0;
    d0 = done_cnt;
    exp_dacc = '0;
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      exp_dacc = exp_dacc ^ v;
      push_blk(1'b0, v, (i == 0) ? gap : 0);
    end
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      exp_res_q.push_back(v ^ exp_dacc);
      push_blk(1'b1, v, 0);
    end
    if (drop_write) write_op(5'd0, HALT_OP);
    for (int i = 0; i < 4; i++) pull_res((i == 0) ? delay : 0);
    wait_idle("enc_finish");
    check("enc_done_once", done_cnt - d0, 1);
    check("enc_error", {127'd0, error}, '0);
    check("enc_halt_instr", {122'd0, instruction}, {122'd0, HALT_OP});
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0] enc_prog [16] = '{
    ASCON_DATA_FIFO_PUSH, ASCON_DATA_FIFO_PUSH, ASCON_DATA_FIFO_PUSH,
    ASCON_TXT_FIFO_PUSH, ASCON_TXT_FIFO_PUSH, ASCON_TXT_FIFO_PUSH, ASCON_TXT_FIFO_PUSH,
    ASCON_KEY_LOAD, ASCON_NONCE_LOAD, ASCON_INIT, ASCON_ENCRYPT,
    ASCON_TEXT_OUT_FIFO_PULL, ASCON_TEXT_OUT_FIFO_PULL, ASCON_TEXT_OUT_FIFO_PULL,
    ASCON_TEXT_OUT_FIFO_PULL, HALT_OP};

  initial begin
    int d0;
    rstn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; fast_mode = 1'b0; blk_valid = 1'b0; blk_data = '0;
    res_ready = 1'b0; core_en = 1'b0;
    cyc(3);
    // reset values
    check("rst_instr", {122'd0, instruction}, {122'd0, 6'h3f});
    check("rst_flags", {121'd0, busy, done, error, data_blk_en, txt_blk_en, res_valid, blk_ready}, '0);
    check("rst_blocks", data_block | txt_block, '0);
    check("rst_fast", {127'd0, compact_fast}, '0);
    rstn = 1'b1;

    // boot: core not ready, start ignored
    cyc(10);
    pulse_start(1'b1);
    cyc(2);
    check("boot_start_ignored", {127'd0, busy}, '0);
    core_en = 1'b1;
    cyc(2);
    for (int i = 0; i < 16; i++) write_op(i[4:0], enc_prog[i]);
    pulse_start(1'b1);
    check("start_busy", {127'd0, busy}, {127'd0, 1'b1});
    check("start_fast", {127'd0, compact_fast}, {127'd0, 1'b1});

    // full program with valid gap, result backpressure and a dropped write
    run_enc(5, 8, 1'b1);

    // reset during S_WAIT
    core_en = 1'b0;
    pulse_start(1'b0);
    push_blk(1'b0, {4{32'hC0FFEE01}}, 0);
    cyc(3);
    check("wait_busy", {127'd0, busy}, {127'd0, 1'b1});
    #2 rstn = 1'b0;
    #1;
    check("midrst_instr", {122'd0, instruction}, {122'd0, 6'h3f});
    check("midrst_flags", {121'd0, busy, done, error, data_blk_en, txt_blk_en, res_valid, blk_ready}, '0);
    check("midrst_blocks", data_block | txt_block | res_data, '0);
    cyc(2);
    rstn = 1'b1;
    pulse_start(1'b0);
    cyc(2);
    check("reboot_start_ignored", {127'd0, busy}, '0);
    core_en = 1'b1;
    cyc(2);
    pulse_start(1'b0);
    check("rerun_busy", {127'd0, busy}, {127'd0, 1'b1});
    check("rerun_fast", {127'd0, compact_fast}, '0);
    run_enc(0, 0, 1'b0);

    // timeout: core never readies
    write_op(5'd0, ASCON_KEY_LOAD);
    write_op(5'd1, HALT_OP);
    core_en = 1'b0;
    d0 = done_cnt;
    pulse_start(1'b0);
    cyc(18);
    check("to_before_error", {127'd0, error}, '0);
    check("to_before_instr", {122'd0, instruction}, {122'd0, ASCON_KEY_LOAD});
    cyc(1);
    check("to_error", {127'd0, error}, {127'd0, 1'b1});
    check("to_instr_halt", {122'd0, instruction}, {122'd0, HALT_OP});
    cyc(3);
    check("to_idle", {127'd0, busy}, '0);
    check("to_no_done", done_cnt - d0, 0);
    check("to_sticky", {127'd0, error}, {127'd0, 1'b1});

    // start clears the sticky error; program now completes
    core_en = 1'b1;
    cyc(2);
    pulse_start(1'b0);
    check("start_clears_error", {127'd0, error}, '0);
    wait_idle("key_finish");
    check("key_done_once", done_cnt - d0, 1);
    check("key_error", {127'd0, error}, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
